// File: rtl/board_uart_loader.sv
// UART-driven board loader: 'L' streams packed cell bits into board memory,
// 'C' clears the whole board. One write per cell, ascending addresses.
module board_uart_loader #(
   parameter int CLKS_PER_BIT = 208,
   parameter int CELLS        = 2048
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rx,
   input  logic        wr_ready,
   output logic        wr_en,
   output logic [10:0] wr_addr,
   output logic        wr_data,
   output logic        busy,
   output logic        frame_err,
   output logic        overrun
);

   localparam logic [11:0] BIT_END  = 12'(CLKS_PER_BIT - 1);
   localparam logic [11:0] HALF_END = 12'(CLKS_PER_BIT / 2 - 1);
   localparam logic [10:0] LAST     = 11'(CELLS - 1);

   typedef enum logic [2:0] {
      R_IDLE, R_START, R_DATA, R_STOP, R_WAIT
   } rx_state_t;

   typedef enum logic [1:0] {
      IDLE, LOAD_WAIT, LOAD_EMIT, CLEAR
   } cmd_state_t;

   logic        rx_s1, rx_s2, rx_prev;
   rx_state_t   rstate, rstate_n;
   logic [11:0] rcnt, rcnt_n;
   logic [2:0]  rbit, rbit_n;
   logic [7:0]  rsh, rsh_n;
   logic        byte_valid, bv_n, fe_n;

   cmd_state_t  state, state_n;
   logic [10:0] addr, addr_n;
   logic [7:0]  sh, sh_n, hold, hold_n;
   logic [2:0]  bc, bc_n;
   logic        hold_full, hf_n, ov_n, accept;

   // Two-flop synchronizer plus one delayed copy for falling-edge detect
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // Receiver state register and registered strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         rstate     <= R_IDLE;
         rcnt       <= '0;
         rbit       <= '0;
         rsh        <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rstate     <= rstate_n;
         rcnt       <= rcnt_n;
         rbit       <= rbit_n;
         rsh        <= rsh_n;
         byte_valid <= bv_n;
         frame_err  <= fe_n;
      end
   end

   // Receiver next state: mid-bit sampling, LSB first, stop-bit check
   always_comb begin
      rstate_n = rstate;
      rcnt_n   = rcnt + 12'd1;
      rbit_n   = rbit;
      rsh_n    = rsh;
      bv_n     = 1'b0;
      fe_n     = 1'b0;
      unique case (rstate)
         R_IDLE: begin
            rcnt_n = '0;
            if (rx_prev && !rx_s2) rstate_n = R_START;
         end
         R_START: begin
            if (rcnt == HALF_END) begin
               rcnt_n = '0;
               rbit_n = '0;
               rstate_n = rx_s2 ? R_IDLE : R_DATA;
            end
         end
         R_DATA: begin
            if (rcnt == BIT_END) begin
               rcnt_n = '0;
               rsh_n  = {rx_s2, rsh[7:1]};
               rbit_n = rbit + 3'd1;
               if (rbit == 3'd7) rstate_n = R_STOP;
            end
         end
         R_STOP: begin
            if (rcnt == BIT_END) begin
               rcnt_n = '0;
               if (rx_s2) begin
                  bv_n     = 1'b1;
                  rstate_n = R_IDLE;
               end else begin
                  fe_n     = 1'b1;
                  rstate_n = R_WAIT;
               end
            end
         end
         R_WAIT: begin
            rcnt_n = '0;
            if (rx_s2) rstate_n = R_IDLE;
         end
         default: rstate_n = R_IDLE;
      endcase
   end

   assign accept = wr_en & wr_ready;

   // Command state register; write port outputs come straight from flops
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         addr      <= '0;
         sh        <= '0;
         bc        <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         overrun   <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_data   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_n;
         addr      <= addr_n;
         sh        <= sh_n;
         bc        <= bc_n;
         hold      <= hold_n;
         hold_full <= hf_n;
         overrun   <= ov_n;
         wr_en     <= (state_n == LOAD_EMIT) || (state_n == CLEAR);
         wr_addr   <= addr_n;
         wr_data   <= (state_n == LOAD_EMIT) && sh_n[0];
         busy      <= state_n != IDLE;
      end
   end

   // Command next state: byte decode, bit emission, holding register
   always_comb begin
      state_n = state;
      addr_n  = addr;
      sh_n    = sh;
      bc_n    = bc;
      hold_n  = hold;
      hf_n    = hold_full;
      ov_n    = 1'b0;
      unique case (state)
         IDLE: begin
            hf_n = 1'b0;
            if (byte_valid && rsh == 8'h4C) begin
               state_n = LOAD_WAIT;
               addr_n  = '0;
            end else if (byte_valid && rsh == 8'h43) begin
               state_n = CLEAR;
               addr_n  = '0;
            end
         end
         LOAD_WAIT: begin
            if (hold_full) begin
               sh_n    = hold;
               bc_n    = '0;
               state_n = LOAD_EMIT;
               if (byte_valid) hold_n = rsh;
               else hf_n = 1'b0;
            end else if (byte_valid) begin
               sh_n    = rsh;
               bc_n    = '0;
               state_n = LOAD_EMIT;
            end
         end
         LOAD_EMIT: begin
            if (byte_valid) begin
               if (hold_full) begin
                  ov_n = 1'b1;
               end else begin
                  hold_n = rsh;
                  hf_n   = 1'b1;
               end
            end
            if (accept) begin
               sh_n = sh >> 1;
               bc_n = bc + 3'd1;
               if (addr == LAST) begin
                  state_n = IDLE;
                  hf_n    = 1'b0;
               end else begin
                  addr_n = addr + 11'd1;
                  if (bc == 3'd7) state_n = LOAD_WAIT;
               end
            end
         end
         CLEAR: begin
            if (accept) begin
               if (addr == LAST) state_n = IDLE;
               else addr_n = addr + 11'd1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_board_uart_loader.sv
// Bench for board_uart_loader: serial command stream in, write log out,
// compared against a cell-level model of what each command should write.
module tb_board_uart_loader;

   localparam int CPB = 4;
   localparam int N   = 16;

   logic        clk = 1'b0;
   logic        reset, rx, wr_ready;
   logic        wr_en, wr_data, busy, frame_err, overrun;
   logic [10:0] wr_addr;

   typedef struct {
      logic [10:0] a;
      logic        d;
      int          cyc;
   } wr_t;

   wr_t  log_q[$];
   wr_t  exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   fe_cnt = 0;
   int   ov_cnt = 0;
   int   ready_mode = 0;
   int   ph = 0;
   logic [7:0] b0, b1, b2;

   board_uart_loader #(.CLKS_PER_BIT(CPB), .CELLS(N)) dut (
      .clk(clk), .reset(reset), .rx(rx), .wr_ready(wr_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // wr_ready driver: 0 always 1, 1 random, 2 pattern 1,0,0,1, 3 always 0
   initial begin
      wr_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: wr_ready = 1'b1;
            1: wr_ready = 1'($urandom % 2);
            2: begin
               wr_ready = (ph == 0 || ph == 3);
               ph = (ph + 1) % 4;
            end
            default: wr_ready = 1'b0;
         endcase
      end
   end

   // Write monitor: logs accepted writes, checks stall stability and
   // that busy drops right after the last cell is written
   initial begin
      logic        prev_stall, last_pend, prev_d;
      logic [10:0] prev_a;
      prev_stall = 1'b0;
      last_pend  = 1'b0;
      prev_d     = 1'b0;
      prev_a     = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (last_pend) begin
            check("busy_after_last", 32'(busy), 0);
            check("wr_en_after_last", 32'(wr_en), 0);
            last_pend = 1'b0;
         end
         if (prev_stall) begin
            check("stall_wr_en", 32'(wr_en), 1);
            check("stall_addr", 32'(wr_addr), 32'(prev_a));
            check("stall_data", 32'(wr_data), 32'(prev_d));
         end
         if (frame_err === 1'b1) fe_cnt++;
         if (overrun === 1'b1) ov_cnt++;
         prev_stall = !reset && wr_en && !wr_ready;
         prev_a = wr_addr;
         prev_d = wr_data;
         if (!reset && wr_en && wr_ready) begin
            log_q.push_back('{a: wr_addr, d: wr_data, cyc: cyc});
            if (wr_addr == 11'(N - 1)) last_pend = 1'b1;
         end
      end
   end

   task automatic send_bit(input logic v);
      #1 rx = v;
      repeat (CPB) @(posedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      @(posedge clk);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop_ok);
      #1 rx = 1'b1;
      repeat (3) @(posedge clk);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", 32'(n < 3000), 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic exp_clear(input int cnt);
      for (int i = 0; i < cnt; i++) exp_q.push_back('{a: 11'(i), d: 1'b0, cyc: 0});
   endtask

   task automatic exp_byte(input logic [7:0] b);
      for (int k = 0; k < 8; k++)
         exp_q.push_back('{a: 11'(exp_q.size()), d: b[k], cyc: 0});
   endtask

   task automatic compare_log(input string tag);
      int m;
      check({tag, "_nwrites"}, 32'(log_q.size()), 32'(exp_q.size()));
      m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) begin
         check($sformatf("%s_addr%0d", tag, i), 32'(log_q[i].a), 32'(exp_q[i].a));
         check($sformatf("%s_data%0d", tag, i), 32'(log_q[i].d), 32'(exp_q[i].d));
      end
   endtask

   task automatic start_op();
      log_q.delete();
      exp_q.delete();
   endtask

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_wr_en", 32'(wr_en), 0);
      check("rst_wr_addr", 32'(wr_addr), 0);
      check("rst_wr_data", 32'(wr_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_frame_err", 32'(frame_err), 0);
      check("rst_overrun", 32'(overrun), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(posedge clk);

      // Clear at full speed: 16 back-to-back zero writes
      start_op();
      send_byte(8'h43, 1'b1);
      wait_idle();
      exp_clear(N);
      compare_log("clear");
      for (int i = 1; i < log_q.size(); i++)
         check($sformatf("clear_consec%0d", i), 32'(log_q[i].cyc - log_q[0].cyc), 32'(i));

      // Directed load
      start_op();
      send_byte(8'h4C, 1'b1);
      send_byte(8'hA5, 1'b1);
      send_byte(8'h01, 1'b1);
      wait_idle();
      exp_byte(8'hA5);
      exp_byte(8'h01);
      compare_log("load_a5");

      // Unknown command byte does nothing
      start_op();
      send_byte(8'h55, 1'b1);
      repeat (10) @(negedge clk);
      check("ignored_busy", 32'(busy), 0);
      check("ignored_nwrites", 32'(log_q.size()), 0);

      // Loads under stalling wr_ready: fixed pattern, then random
      for (int it = 0; it < 4; it++) begin
         start_op();
         ph = 0;
         ready_mode = (it == 0) ? 2 : 1;
         b0 = 8'($urandom);
         b1 = 8'($urandom);
         send_byte(8'h4C, 1'b1);
         send_byte(b0, 1'b1);
         send_byte(b1, 1'b1);
         wait_idle();
         ready_mode = 0;
         exp_byte(b0);
         exp_byte(b1);
         compare_log($sformatf("rload%0d", it));
      end

      // Stalled load: one byte held, the next dropped
      start_op();
      ready_mode = 3;
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      b2 = 8'($urandom);
      send_byte(8'h4C, 1'b1);
      send_byte(b0, 1'b1);
      send_byte(b1, 1'b1);
      send_byte(b2, 1'b1);
      repeat (4) @(negedge clk);
      check("ovr_pulses", 32'(ov_cnt), 1);
      check("ovr_busy", 32'(busy), 1);
      check("ovr_nwrites", 32'(log_q.size()), 0);
      ready_mode = 0;
      wait_idle();
      exp_byte(b0);
      exp_byte(b1);
      compare_log("ovr");
      check("ovr_pulses_end", 32'(ov_cnt), 1);

      // Bad stop bit on a 'C': discarded, then a good 'C' runs
      start_op();
      send_byte(8'h43, 1'b0);
      repeat (20) @(negedge clk);
      check("fe_pulses", 32'(fe_cnt), 1);
      check("fe_busy", 32'(busy), 0);
      check("fe_nwrites", 32'(log_q.size()), 0);
      send_byte(8'h43, 1'b1);
      wait_idle();
      exp_clear(N);
      compare_log("fe_clear");
      check("fe_pulses_end", 32'(fe_cnt), 1);

      // Reset right after address 5 of a clear
      start_op();
      send_byte(8'h43, 1'b1);
      begin
         int n;
         n = 0;
         while (!(wr_en && wr_ready && wr_addr == 11'd5) && n < 500) begin
            @(negedge clk);
            n++;
         end
         check("rst_mid_timeout", 32'(n < 500), 1);
      end
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_mid_wr_en", 32'(wr_en), 0);
      check("rst_mid_busy", 32'(busy), 0);
      repeat (5) @(negedge clk);
      exp_clear(6);
      compare_log("rst_mid");

      // Load after the aborted clear starts again at address 0
      start_op();
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      send_byte(8'h4C, 1'b1);
      send_byte(b0, 1'b1);
      send_byte(b1, 1'b1);
      wait_idle();
      exp_byte(b0);
      exp_byte(b1);
      compare_log("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/board_uart_loader.md
BOARD_UART_LOADER -- requirements
Module: board_uart_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 208, meaning clock cycles per UART bit (24 MHz / 115200); legal range 4..4095.
REQ-002 SHALL have parameter CELLS, default 2048, meaning board size in cells (64x32); must be a multiple of 8.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port rx, input, 1, asynchronous UART receive line, idle high.
REQ-006 SHALL have port wr_ready, input, 1, high when the board memory accepts a write this cycle.
REQ-007 SHALL have port wr_en, output, 1, write request to board memory.
REQ-008 SHALL have port wr_addr, output, 11, cell index (row<<6 | column).
REQ-009 SHALL have port wr_data, output, 1, cell value (1 = live).
REQ-010 SHALL have port busy, output, 1, high while a load or clear is in progress.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse on a bad stop bit.
REQ-012 SHALL have port overrun, output, 1, one-cycle pulse when a received byte is dropped.

Function
REQ-013 SHALL pass rx through a two-flop synchronizer before any use, adding 2 cycles of latency.
REQ-014 UART receiver SHALL detect a start bit on a synchronized high-to-low transition, re-sample at CLKS_PER_BIT/2, and return to idle without output if the line is high there.
REQ-015 Receiver SHALL sample 8 data bits LSB first and then the stop bit, each CLKS_PER_BIT cycles after the previous sample.
REQ-016 Stop bit 0 SHALL discard the byte, pulse frame_err for one cycle, and return the receiver to idle once rx is high.
REQ-017 A valid byte SHALL be presented to the command FSM as a one-cycle byte_valid strobe in the cycle after the stop-bit sample.
REQ-018 Command FSM states: IDLE, LOAD_WAIT, LOAD_EMIT, CLEAR.
REQ-019 IDLE: byte 0x4C ('L') -> LOAD_WAIT, address counter = 0; byte 0x43 ('C') -> CLEAR, address counter = 0; all other bytes are ignored.
REQ-020 LOAD_WAIT: a valid byte SHALL be latched into an 8-bit shift register with bit counter = 0 -> LOAD_EMIT.
REQ-021 LOAD_EMIT: wr_en = 1, wr_data = shift register bit 0, wr_addr = address counter.
REQ-022 In LOAD_EMIT, a cycle with wr_en & wr_ready SHALL accept the write: shift register right, increment bit counter, increment address.
REQ-023 LOAD_EMIT: after the 8th accepted write -> LOAD_WAIT; if that write was at address CELLS-1 -> IDLE instead.
REQ-024 A byte arriving in LOAD_EMIT SHALL be held in a one-byte holding register and consumed instead of waiting when LOAD_WAIT is next entered.
REQ-025 A byte arriving while the holding register is full SHALL be dropped, with a one-cycle overrun pulse.
REQ-026 CLEAR: wr_en = 1, wr_data = 0; address increments on each accepted write; after the write at CELLS-1 -> IDLE; UART bytes received in CLEAR are ignored.
REQ-027 wr_en, wr_addr and wr_data SHALL be registered and stable while wr_en = 1 and wr_ready = 0.
REQ-028 Address counter SHALL never wrap; address CELLS-1 is the last write of any load or clear.
REQ-029 busy SHALL be 1 in LOAD_WAIT, LOAD_EMIT and CLEAR, and 0 in IDLE.
REQ-030 A write at a given address SHALL occur exactly once per load or clear, in ascending address order.

Reset
REQ-031 Reset SHALL force: FSM = IDLE; receiver idle; holding register empty; synchronizer flops = 1; address = 0; wr_en = 0; wr_addr = 0; wr_data = 0; busy = 0; frame_err = 0; overrun = 0.
REQ-032 Reset asserted mid-load or mid-clear SHALL abandon the operation on the next edge with no further writes; a partial board is left as written.

Verification (bench uses CLKS_PER_BIT=4, CELLS=16 unless stated)
REQ-033 Stimulus: 'C' with wr_ready=1. Required: 16 consecutive writes, addr 0..15, data 0; busy falls the cycle after addr 15.
REQ-034 Stimulus: 'L', 0xA5, 0x01 with wr_ready=1. Required: addr 0..7 data 1,0,1,0,0,1,0,1; addr 8..15 data 1,0,0,0,0,0,0,0; then IDLE.
REQ-035 Stimulus: wr_ready toggling 1,0,0,1 during a load. Required: wr_addr and wr_data unchanged across stalled cycles; no skipped or duplicate addresses.
REQ-036 Stimulus: wr_ready=0 during a load while 2 further bytes arrive. Required: first byte held and later emitted; second byte dropped with one overrun pulse.
REQ-037 Stimulus: byte sent with stop bit 0. Required: one frame_err pulse; no state change; the following good 'C' executes normally.
REQ-038 Stimulus: reset asserted for 1 cycle after addr 5 of a clear. Required: next cycle wr_en=0, busy=0; a subsequent 'L' starts at addr 0.
